// File: rtl/red_d.sv
// red_d -- pipelined Barrett reducer for the Dilithium modulus q = 8380417.
//
// Computes result_o = product_i mod q for any 46-bit unsigned product. The
// result is a canonical residue in [0, q-1]. The block accepts one operand per
// clock, has no backpressure, and keeps operands in order.
//
// Ports:
//   clk_i      in   1   clock, rising edge
//   rst_ni     in   1   asynchronous active-low reset
//   valid_i    in   1   product_i is valid this cycle
//   product_i  in  46   unsigned operand
//   valid_o    out  1   result_o is valid this cycle
//   result_o   out 23   product_i mod 8380417; holds its last value while valid_o = 0
//
// Optional build macro:
//   RED_D_OUTREG_EN  adds a register stage after the final correction.
//                    Latency is 3 with the macro defined and 2 without it.
//
// Pipeline:
//   p1  registers the operand x.
//   p2  registers qhat = (x * m) >> 46 together with the low 25 bits of x.
//   p3  registers the corrected residue x - qhat*q.
//   p4  (RED_D_OUTREG_EN only) is an extra output register.
module red_d (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  input  logic [45:0] product_i,
  output logic        valid_o,
  output logic [22:0] result_o
);

  localparam logic [24:0] Q25   = 25'd8380417;
  localparam logic [24:0] Q2_25 = 25'd16760834;
  localparam logic [69:0] M70   = 70'd8396807;  // floor(2^46 / q)

  // The Barrett estimate undershoots by at most two, so r < 3q.
  // Comparing r against both q and 2q in parallel is equivalent to two
  // cascaded conditional subtractions, and it is shallower.
  function automatic logic [22:0] reduce3q(input logic [24:0] r);
    if (r >= Q2_25) begin
      reduce3q = 23'(r - Q2_25);
    end else if (r >= Q25) begin
      reduce3q = 23'(r - Q25);
    end else begin
      reduce3q = r[22:0];
    end
  endfunction

  logic [45:0] x_p1_q;
  logic        vld_p1_q;
  logic [23:0] qhat_p2_d, qhat_p2_q;
  logic [24:0] xlo_p2_d, xlo_p2_q;
  logic        vld_p2_q;
  logic [24:0] r_p3;
  logic [22:0] res_p3_d, res_p3_q;
  logic        vld_p3_q;

  // ---- stage p1: operand capture ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_p1_q   <= '0;
      vld_p1_q <= 1'b0;
    end else begin
      x_p1_q   <= product_i;
      vld_p1_q <= valid_i;
    end
  end

  // The full 70-bit product must be formed before the shift.
  // qhat < m < 2^24, so the top 24 bits hold all of qhat.
  assign qhat_p2_d = 24'(({24'b0, x_p1_q} * M70) >> 46);
  // r = x - qhat*q is known to be below 2^25, so only the low 25 bits of x
  // and of qhat*q affect the result. Modular wrap in 25 bits gives exact r.
  assign xlo_p2_d  = x_p1_q[24:0];

  // ---- stage p2: quotient estimate ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      qhat_p2_q <= '0;
      xlo_p2_q  <= '0;
      vld_p2_q  <= 1'b0;
    end else begin
      qhat_p2_q <= qhat_p2_d;
      xlo_p2_q  <= xlo_p2_d;
      vld_p2_q  <= vld_p1_q;
    end
  end

  assign r_p3     = xlo_p2_q - ({1'b0, qhat_p2_q} * Q25);
  assign res_p3_d = reduce3q(r_p3);

`ifdef RED_D_OUTREG_EN
  logic [22:0] res_p4_q;
  logic        vld_p4_q;

  // ---- stage p3: corrected residue ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_p3_q <= '0;
      vld_p3_q <= 1'b0;
    end else begin
      res_p3_q <= res_p3_d;
      vld_p3_q <= vld_p2_q;
    end
  end

  // ---- stage p4: output register, holds its value across invalid cycles ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_p4_q <= '0;
      vld_p4_q <= 1'b0;
    end else begin
      vld_p4_q <= vld_p3_q;
      if (vld_p3_q) begin
        res_p4_q <= res_p3_q;
      end
    end
  end

  assign valid_o  = vld_p4_q;
  assign result_o = res_p4_q;
`else
  // ---- stage p3: corrected residue, also the output register ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_p3_q <= '0;
      vld_p3_q <= 1'b0;
    end else begin
      vld_p3_q <= vld_p2_q;
      if (vld_p2_q) begin
        res_p3_q <= res_p3_d;
      end
    end
  end

  assign valid_o  = vld_p3_q;
  assign result_o = res_p3_q;
`endif

endmodule

// File: tb/tb_red_d.sv
module tb_red_d;

`ifdef RED_D_OUTREG_EN
  localparam int L = 3;
`else
  localparam int L = 2;
`endif

  localparam logic [127:0] Q128  = 128'd8380417;
  localparam logic [127:0] QQ128 = 128'd70231389093889;

  logic        clk_i;
  logic        rst_ni;
  logic        valid_i;
  logic [45:0] product_i;
  logic        valid_o;
  logic [22:0] result_o;

  int checks;
  int failures;

  // Expected-output model: index 0 is the operand sampled at the latest edge.
  logic        mv [0:3];
  logic [22:0] me [0:3];

  logic [127:0] lcg;

  red_d dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .product_i(product_i),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      mv[i] = 1'b0;
      me[i] = '0;
    end
  endtask

  // Drive one operand, clock it in, then check the output against the model.
  task automatic step(input logic v, input logic [45:0] x, input logic [22:0] e);
    valid_i   = v;
    product_i = x;
    @(posedge clk_i);
    #1;
    for (int i = 3; i > 0; i--) begin
      mv[i] = mv[i-1];
      me[i] = me[i-1];
    end
    mv[0] = v;
    me[0] = e;
    chk("valid_o", {63'b0, valid_o}, {63'b0, mv[L]});
    if (mv[L]) chk("result_o", {41'b0, result_o}, {41'b0, me[L]});
  endtask

  task automatic flush();
    for (int i = 0; i < L + 1; i++) step(1'b0, 46'd0, 23'd0);
  endtask

  // One-cycle reset pulse applied mid-stream with valid_i held high.
  task automatic pulse_reset();
    valid_i = 1'b1;
    rst_ni  = 1'b0;
    #1;
    chk("rst_async_valid_o", {63'b0, valid_o}, 64'd0);
    chk("rst_async_result_o", {41'b0, result_o}, 64'd0);
    @(posedge clk_i);
    #1;
    chk("rst_hold_valid_o", {63'b0, valid_o}, 64'd0);
    rst_ni = 1'b1;
    clear_model();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    clear_model();
    rst_ni    = 1'b0;
    valid_i   = 1'b1;
    product_i = 46'd8380420;

    // Reset with valid_i held high
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_valid_o", {63'b0, valid_o}, 64'd0);
    chk("reset_result_o", {41'b0, result_o}, 64'd0);
    rst_ni = 1'b1;

    // First operand after release: the model checks valid_o on every cycle
    step(1'b1, 46'd77, 23'd77);
    flush();

    // Boundary operands back-to-back
    step(1'b1, 46'd0,              23'd0);
    step(1'b1, 46'd8380416,        23'd8380416);
    step(1'b1, 46'd8380417,        23'd0);
    step(1'b1, 46'd16760839,       23'd5);
    step(1'b1, 46'd70231389093888, 23'd8380416);
    step(1'b1, 46'd70368744177663, 23'd49144);
    flush();

    // Gapped stream 1,0,0,1,1,0
    step(1'b1, 46'd100,            23'd100);
    step(1'b0, 46'd999,            23'd0);
    step(1'b0, 46'd12,             23'd0);
    step(1'b1, 46'd8380418,        23'd1);
    step(1'b1, 46'd25141251,       23'd0);
    step(1'b0, 46'd70231389093896, 23'd0);
    step(1'b1, 46'd70231389093896, 23'd7);
    flush();

    // Reset with operands in flight: none may emerge
    for (int i = 0; i < L; i++) step(1'b1, 46'(1000 + i), 23'(1000 + i));
    pulse_reset();
    flush();
    step(1'b1, 46'd16760841, 23'd7);
    step(1'b1, 46'd12345,    23'd12345);
    flush();

    // LCG sweep, valid_i held high
    lcg = 128'h2D71F035BA3;
    for (int n = 0; n < 3000; n++) begin
      step(1'b1, lcg[45:0], 23'(lcg % Q128));
      lcg = (lcg * 128'd649731) % QQ128;
    end
    flush();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
